sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Shares one read port of the on-chip sprite/map ROM between the viewport index generators: background, area, enemy, Kirby and star.
- Each generator presents its computed index as a request. The block grants one per cycle in round-robin order, drives the ROM address, and routes the returned palette byte back to the owning requester.
- It sits between the index generators and the ROM, feeding the colour mapper.
- Fully pipelined: one accept per cycle, fixed latency.

Parameters:
- NUM_REQ, 5, number of requesters. Index map: 0 background, 1 area, 2 enemy, 3 Kirby, 4 star.
- ADDR_W, 18, ROM address width; matches the widest index generator output.
- DATA_W, 8, ROM word width (palette index).
- READ_LAT, 2, ROM latency: edges from the ROM sampling rom_addr until rom_data is valid.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at vertical sync; restarts round-robin
- req_valid  in  NUM_REQ  per-requester request
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rom_en  out  1  ROM read enable, registered
- rom_addr  out  ADDR_W  ROM address, registered
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_W  response data, registered
- inflight  out  $clog2(READ_LAT+2)  number of accepted reads not yet responded

Behaviour:
- Reset (async, Reset_n=0): rr_ptr=0, tag pipeline cleared, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, inflight=0.
  - Reset mid-operation drops all in-flight reads; no response is ever produced for them.
- Grant (combinational):
  - Select the first i with req_valid[i]=1, searching circularly from rr_ptr.
  - req_ready is one-hot for that i; it is all zero if no request is valid.
  - req_ready never depends on rsp_valid or inflight; there is no backpressure.
- Accept: req_valid[i] & req_ready[i] sampled at an edge (E0).
  - At E0: rom_addr <= req_addr[i], rom_en <= 1, tag[0] <= onehot(i).
  - Cycles with no accept: rom_en <= 0, rom_addr holds its value.
- Tag pipeline: depth READ_LAT+1, one-hot per stage, shifts every cycle.
- Response timing (latency READ_LAT+1 edges from accept):
  - ROM samples rom_addr at E1; rom_data is valid after E(READ_LAT).
  - At E(READ_LAT+1): rsp_data <= rom_data, rsp_valid <= last tag.
  - With defaults, an accept at edge 0 gives rsp_valid high in the cycle after edge 3.
- Round-robin pointer:
  - After an accept from i: rr_ptr <= (i+1) mod NUM_REQ. No accept: unchanged.
  - frame_start=1: rr_ptr <= 0, and this overrides a simultaneous accept update.
  - The accept itself still proceeds, and in-flight reads complete normally.
- Requester behaviour: a requester holding req_valid with no grant keeps its address stable; the arbiter does not latch it.
  - Maximum wait is NUM_REQ-1 cycles after the requester becomes valid.
- inflight: +1 on accept, -1 on response, unchanged when both happen in the same cycle. It never exceeds READ_LAT+1.
- rsp_valid is at most one-hot. rsp_data is only meaningful while rsp_valid is non-zero; it holds its value otherwise.
- NUM_REQ=1: the grant degenerates to req_ready=req_valid, and rr_ptr stays 0.
- Simultaneous frame_start and reset: reset dominates.

Decomposition:
- Shared package sprite_pkg:
  - SPRITE_ADDR_W=18, PAL_W=8
  - requester index constants REQ_BACK=0, REQ_AREA=1, REQ_ENEMY=2, REQ_KIRBY=3, REQ_STAR=4
  - typedef for the one-hot tag vector
- One sub-module, rr_grant: combinational round-robin priority selector (inputs req and rr_ptr, output one-hot grant plus binary index).
  - Reused later for the sound-channel mixer.

Test Plan:
- Reset release with req_valid=5'b11111 -> grants on consecutive cycles go to 0,1,2,3,4,0; rom_addr follows req_addr in the same order; each rsp_valid bit fires exactly 3 cycles after its grant.
- Only requester 3 valid, addr=18'h1_2345, ROM model returns addr[7:0] -> req_ready=5'b01000 every cycle; rsp_data=8'h45 with rsp_valid=5'b01000 three cycles after each accept; inflight stays at 3 at steady state.
- rr_ptr=2 (after a grant to 1), req_valid=5'b00011 -> grant to 0 (wrap-around), next grant to 1.
- frame_start asserted in the same cycle as a grant to 3, req_valid=5'b11111 -> that read completes; the next grant goes to 0, not 4.
- Two reads in flight, Reset_n pulled low for 1 cycle -> rsp_valid stays 0 forever after; inflight=0; the first grant after release goes to requester 0.
- req_valid=0 for 10 cycles -> rom_en=0, rsp_valid=0, inflight=0; rr_ptr is unchanged (checked by the next grant order).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite-path constants: ROM geometry, requester index map, tag type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sprite_pkg;

  localparam int SPRITE_ADDR_W  = 18;
  localparam int PAL_W          = 8;

  // Requester index map into the arbiter's req_* vectors.
  localparam int REQ_BACK       = 0;
  localparam int REQ_AREA       = 1;
  localparam int REQ_ENEMY      = 2;
  localparam int REQ_KIRBY      = 3;
  localparam int REQ_STAR       = 4;
  localparam int SPRITE_NUM_REQ = REQ_STAR + 1;

  // One-hot owner tag carried alongside each outstanding ROM read.
  typedef logic [SPRITE_NUM_REQ-1:0] req_onehot_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_grant.sv
// Round-robin priority selector: first set request at or after i_ptr, circularly.
// Latency: combinational.
// Backpressure: none; o_grant is all zero when no request is set.
//
// Ports:
//   i_req   N-bit request vector
//   i_ptr   index that has highest priority this cycle (must be < N)
//   o_grant one-hot grant (or zero)
//   o_idx   binary index of the granted request (0 when nothing granted)
module rr_grant #(
  parameter int N     = 5,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = PTR_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite/map ROM read port among the viewport index generators, round-robin.
// Latency: READ_LAT+1 edges from accept to rsp_valid/rsp_data; one accept per cycle.
// Backpressure: none; req_ready is a pure function of req_valid and the rr pointer.
//
// Ports:
//   Clk, Reset_n          clock, async active-low reset
//   frame_start           vsync pulse; resets the rr pointer to requester 0
//   req_valid/req_addr    per-requester request and flattened address
//   req_ready             one-hot combinational grant
//   rom_en/rom_addr       registered ROM read strobe and address
//   rom_data              ROM read data, valid READ_LAT edges after ROM samples rom_addr
//   rsp_valid/rsp_data    registered one-hot response strobe and palette byte
//   inflight              accepted reads not yet responded
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ  = SPRITE_NUM_REQ,
  parameter int ADDR_W   = SPRITE_ADDR_W,
  parameter int DATA_W   = PAL_W,
  parameter int READ_LAT = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = $clog2(READ_LAT + 2)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [CNT_W-1:0]          inflight
);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_accept;
  logic               w_rsp;
  // r_tag[0] is written at the accept edge; r_tag[READ_LAT] lines up with rom_data.
  logic [NUM_REQ-1:0] r_tag [READ_LAT+1];

  rr_grant #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (req_ready),
    .o_idx   (w_idx)
  );

  assign w_accept = |req_ready;
  assign w_rsp    = |r_tag[READ_LAT];

  always_comb begin
    w_next_ptr = '0;
    if (w_idx != PTR_W'(NUM_REQ - 1)) begin
      w_next_ptr = w_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr  <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
      for (int k = 0; k <= READ_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      rom_en <= w_accept;
      if (w_accept) begin
        rom_addr <= req_addr[w_idx*ADDR_W +: ADDR_W];
      end

      r_tag[0] <= req_ready;
      for (int k = 1; k <= READ_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end

      rsp_valid <= r_tag[READ_LAT];
      if (w_rsp) begin
        rsp_data <= rom_data;
      end

      // Vsync restart wins over the post-accept advance.
      if (frame_start) begin
        r_rr_ptr <= '0;
      end else if (w_accept) begin
        r_rr_ptr <= w_next_ptr;
      end

      case ({w_accept, w_rsp})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
